sparse_event_encoder: RTL
=========================

SPARSE_EVENT_ENCODER -- requirements
Module: sparse_event_encoder

Interface
REQ-001 SHALL have parameter SIZE, default 8: width of the dense event vector, a power of two >= 2.
REQ-002 SHALL have parameter ADDR_W, default $clog2(SIZE): width of an emitted address.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port enable, input, 1: global enable; low freezes all state.
REQ-006 SHALL have port events_in, input, SIZE: dense event vector; bit i set means address i is active.
REQ-007 SHALL have port load, input, 1: capture events_in on this cycle when in_ready is high.
REQ-008 SHALL have port in_ready, output, 1: load is accepted this cycle.
REQ-009 SHALL have port addr_out, output, ADDR_W: address currently offered downstream.
REQ-010 SHALL have port addr_valid, output, 1: addr_out is valid.
REQ-011 SHALL have port addr_ready, input, 1: downstream consumer accepts addr_out.
REQ-012 SHALL have port last, output, 1: addr_out is the final outstanding address.
REQ-013 SHALL have port done, output, 1: one-cycle pulse when a burst has fully drained.
REQ-014 SHALL have port count, output, ADDR_W+1: number of addresses emitted in the current or most recent burst, saturating.

Function
REQ-015 SHALL implement states IDLE, EMIT and DONE, held in a register with a pending register of SIZE bits and a current-address register of ADDR_W bits.
REQ-016 SHALL define accept as load & in_ready, with in_ready = enable & (state != DONE).
REQ-017 SHALL define handshake as addr_valid & addr_ready; addr_valid = enable & (state == EMIT).
REQ-018 SHALL, in IDLE on accept with events_in nonzero, set pending = events_in, set count = 0 and enter EMIT; addr_valid rises the next cycle.
REQ-019 SHALL, in IDLE on accept with events_in all zero, enter DONE without asserting addr_valid and set count = 0.
REQ-020 SHALL drive addr_out from the current-address register, which holds the lowest set index of pending.
REQ-021 SHALL update the current-address register only on entry to EMIT or on a handshake, so addr_out stays stable while addr_valid is high and addr_ready is low.
REQ-022 SHALL, on a handshake, clear pending[addr_out] and increment count, saturating at 2^(ADDR_W+1)-1.
REQ-023 SHALL sustain one address per cycle while addr_ready is held high.
REQ-024 SHALL, on accept during EMIT, set pending_next = (pending & ~handshake_cleared_bit) | events_in, which merges new events into the burst without resetting count.
REQ-025 SHALL emit merged bits with index below the current addr_out after the current address, in ascending order from the next handshake.
REQ-026 SHALL re-emit a merged bit equal to the address being handshaked in the same cycle later as a new event.
REQ-027 SHALL silently coalesce a merged bit that is already pending.
REQ-028 SHALL assert last = addr_valid & (exactly one bit set in pending).
REQ-029 SHALL, when a handshake leaves pending_next zero, enter DONE.
REQ-030 SHALL, in DONE, assert done for exactly one cycle, deassert in_ready and addr_valid, then return to IDLE.
REQ-031 SHALL, while enable is low, hold state, pending, current address and count, and force addr_valid, in_ready, last and done low.
REQ-032 SHALL ignore addr_ready outside EMIT and ignore load whenever in_ready is low.

Reset
REQ-033 SHALL, on reset high at a clock edge regardless of state or enable, set state to IDLE, pending to 0, current address to 0 and count to 0.
REQ-034 SHALL produce the following output values the cycle after reset: addr_out = 0, addr_valid = 0, last = 0, done = 0, count = 0, in_ready = enable.
REQ-035 SHALL, on reset during EMIT, discard all outstanding addresses with no done pulse.

Verification
REQ-036 SHALL verify basic drain: SIZE=8, addr_ready=1, load events_in=8'b1010_0100 at cycle 0 -> addr_out 2,5,7 valid at cycles 1,2,3; last only at cycle 3; done at cycle 4; count=3.
REQ-037 SHALL verify backpressure: same load with addr_ready=0 for cycles 1-3 -> addr_out=2 and addr_valid=1 held stable for cycles 1-4; 5 and 7 follow on cycles 5 and 6.
REQ-038 SHALL verify merge: during the handshake of addr 5 with pending {5,7}, load 8'b0000_0001 -> next addresses are 0 then 7; done after 7; count=4.
REQ-039 SHALL verify empty load: load 8'h00 in IDLE -> no addr_valid; done high on the next cycle only; in_ready low for that cycle.
REQ-040 SHALL verify reset and freeze: reset asserted while addr_out=5 is valid -> next cycle addr_valid=0 with no done; separately, enable low for 2 cycles mid-burst -> outputs low, and the burst resumes at the same address.

Source files
------------

// File: rtl/sparse_event_encoder.sv
// Dense-to-sparse event encoder: captures a one-hot-per-address event vector and
// streams the set indices in ascending order over a valid/ready address port.
module sparse_event_encoder #(
    parameter int SIZE   = 8,
    parameter int ADDR_W = $clog2(SIZE)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [SIZE-1:0]   events_in,
    input  logic              load,
    output logic              in_ready,
    output logic [ADDR_W-1:0] addr_out,
    output logic              addr_valid,
    input  logic              addr_ready,
    output logic              last,
    output logic              done,
    output logic [ADDR_W:0]   count
);

    typedef enum logic [1:0] {IDLE = 2'd0, EMIT = 2'd1, DONE = 2'd2} state_t;

    state_t            state_q, state_d;
    logic [SIZE-1:0]   pend_q, pend_d;
    logic [ADDR_W-1:0] cur_q, cur_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;

    logic              accept, hs;
    logic [SIZE-1:0]   clr_bit, merged;

    function automatic logic [ADDR_W-1:0] lowest(input logic [SIZE-1:0] v);
        logic [ADDR_W-1:0] idx;
        idx = '0;
        for (int i = SIZE - 1; i >= 0; i--)
            if (v[i]) idx = ADDR_W'(i);
        return idx;
    endfunction

    assign in_ready   = enable & (state_q != DONE);
    assign addr_valid = enable & (state_q == EMIT);
    assign done       = enable & (state_q == DONE);
    assign last       = addr_valid & $onehot(pend_q);
    assign addr_out   = cur_q;
    assign count      = cnt_q;

    assign accept  = load & in_ready;
    assign hs      = addr_valid & addr_ready;
    // Clear the handshaked bit before OR-ing new events, so a reloaded
    // address equal to the one just sent is emitted again later.
    assign clr_bit = hs ? (SIZE'(1) << cur_q) : '0;
    assign merged  = (pend_q & ~clr_bit) | (accept ? events_in : '0);

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        cur_d   = cur_q;
        cnt_d   = cnt_q;
        if (enable) begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        cnt_d = '0;
                        if (|events_in) begin
                            pend_d  = events_in;
                            cur_d   = lowest(events_in);
                            state_d = EMIT;
                        end else begin
                            state_d = DONE;
                        end
                    end
                end
                EMIT: begin
                    pend_d = merged;
                    // Address only advances on a handshake to keep addr_out stable under backpressure.
                    if (hs) begin
                        cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
                        cur_d = lowest(merged);
                        if (merged == '0) state_d = DONE;
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            pend_q  <= '0;
            cur_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            cur_q   <= cur_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
